// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, direction,
// responder FSM states and the bit layout of the registered control bundle.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    // Bit positions inside the registered memory-control bundle.
    localparam int unsigned CTL_SIZE_HI = 6;
    localparam int unsigned CTL_SIZE_LO = 5;
    localparam int unsigned CTL_RW      = 4;
    localparam int unsigned CTL_SE      = 3;
    localparam int unsigned CTL_EN      = 0;

    // Bytes are always aligned; the reserved size code behaves as a word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lsb[0];
            default: ok = (lsb == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with four independent byte lanes.
// Lane 3 holds bits [31:24], which is the lowest byte address of the word.
module dmem_byte_ram #(
    parameter int unsigned WORD_AW = 7
) (
    input  logic               clk,
    input  logic [WORD_AW-1:0] addr,
    input  logic [3:0]         we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [7:0] mem [4][2**WORD_AW];

    // Per-lane synchronous write and a registered full-word read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[i][addr] <= wdata[8*i +: 8];
            end
        end
        rdata <= {mem[3][addr], mem[2][addr], mem[1][addr], mem[0][addr]};
    end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data-memory responder: accepts an aligned request, stalls the
// pipeline for a fixed latency, then commits the store or returns the load.
module mem_stage_dmem
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_rw,
    input  logic [1:0]  mem_size,
    input  logic        mem_se,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        misaligned
);

    localparam int unsigned CntW   = $clog2(LATENCY + 1);
    localparam int unsigned WordAw = ADDR_W - 2;

    dmem_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              se_q;
    logic [31:0]       wdata_q;

    logic        aligned;
    logic        accept;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Upper address bits are discarded so the RAM wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_W];

    assign aligned   = is_aligned(mem_size, address[1:0]);
    assign accept    = (state_q == StIdle) && mem_enable && aligned;
    // Low in DONE so the pipeline advances on the completing edge.
    assign mem_stall = accept || (state_q == StWait);

    // Next-state and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = CntW'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance; the pipeline may move on afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            rw_q    <= RW_READ;
            size_q  <= SZ_BYTE;
            se_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= address[ADDR_W-1:0];
            rw_q    <= mem_rw;
            size_q  <= mem_size;
            se_q    <= mem_se;
            wdata_q <= data_in;
        end
    end

    // Store lane steering; lanes are enabled only in DONE so a reset drops the write.
    always_comb begin
        ram_wdata = wdata_q;
        ram_we    = 4'b0000;
        case (size_q)
            SZ_BYTE: begin
                ram_wdata = {4{wdata_q[7:0]}};
                ram_we    = 4'b1000 >> addr_q[1:0];
            end
            SZ_HALF: begin
                ram_wdata = {2{wdata_q[15:0]}};
                ram_we    = addr_q[1] ? 4'b0011 : 4'b1100;
            end
            default: ram_we = 4'b1111;
        endcase
        if (!((state_q == StDone) && (rw_q == RW_WRITE))) begin
            ram_we = 4'b0000;
        end
    end

    dmem_byte_ram #(
        .WORD_AW (WordAw)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_q[ADDR_W-1:2]),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = ram_rdata[31:24];
            2'd1:    load_byte = ram_rdata[23:16];
            2'd2:    load_byte = ram_rdata[15:8];
            default: load_byte = ram_rdata[7:0];
        endcase
        load_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        case (size_q)
            SZ_BYTE: load_data = {{24{se_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_data = {{16{se_q & load_half[15]}}, load_half};
            default: load_data = ram_rdata;
        endcase
    end

    // Registered completion, misalignment pulse and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            mem_done   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            mem_done   <= (state_q == StDone);
            misaligned <= (state_q == StIdle) && mem_enable && !aligned;
            if ((state_q == StDone) && (rw_q == RW_READ)) begin
                data_out <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed and randomized bench for mem_stage_dmem against a byte-array model.
module tb_mem_stage_dmem;

    localparam int unsigned LATENCY = 2;

    logic        clk;
    logic        reset;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_se;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_stall;
    logic        mem_done;
    logic        misaligned;

    int passed = 0;
    int total  = 0;

    logic [7:0]  ref_mem [512];
    logic [31:0] exp_dout;

    mem_stage_dmem #(
        .ADDR_W  (9),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_size   (mem_size),
        .mem_se     (mem_se),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .mem_stall  (mem_stall),
        .mem_done   (mem_done),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                        input logic [31:0] d);
        logic [8:0] b;
        b = a[8:0];
        case (sz)
            2'd0: ref_mem[b] = d[7:0];
            2'd1: begin
                ref_mem[b]        = d[15:8];
                ref_mem[9'(b + 1)] = d[7:0];
            end
            default: begin
                ref_mem[b]         = d[31:24];
                ref_mem[9'(b + 1)] = d[23:16];
                ref_mem[9'(b + 2)] = d[15:8];
                ref_mem[9'(b + 3)] = d[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic se);
        logic [8:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = a[8:0];
        case (sz)
            2'd0: v = se ? 32'($signed(ref_mem[b])) : {24'd0, ref_mem[b]};
            2'd1: begin
                h = {ref_mem[b], ref_mem[9'(b + 1)]};
                v = se ? 32'($signed(h)) : {16'd0, h};
            end
            default: v = {ref_mem[b], ref_mem[9'(b + 1)], ref_mem[9'(b + 2)], ref_mem[9'(b + 3)]};
        endcase
        return v;
    endfunction

    // One pipeline request, held until the responder releases the stall.
    task automatic access(input logic rw, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] d);
        int   stalls;
        logic al;
        al = (sz == 2'd0) || ((sz == 2'd1) ? !a[0] : (a[1:0] == 2'b00));
        @(negedge clk);
        mem_enable = 1'b1;
        mem_rw     = rw;
        mem_size   = sz;
        mem_se     = se;
        address    = a;
        data_in    = d;
        #1;
        if (!al) begin
            check("mis_stall", {31'd0, mem_stall}, 32'd0);
            @(posedge clk);
            #1;
            mem_enable = 1'b0;
            check("mis_pulse", {31'd0, misaligned}, 32'd1);
            check("mis_dout", data_out, exp_dout);
            @(posedge clk);
            #1;
            check("mis_clear", {31'd0, misaligned}, 32'd0);
        end else begin
            stalls = 0;
            while (mem_stall && stalls < 20) begin
                stalls++;
                @(negedge clk);
                #1;
            end
            check("stall_cycles", 32'(stalls), 32'(LATENCY + 1));
            check("done_early", {31'd0, mem_done}, 32'd0);
            @(posedge clk);
            #1;
            mem_enable = 1'b0;
            if (rw) model_store(a, sz, d);
            else exp_dout = model_load(a, sz, se);
            check("done_pulse", {31'd0, mem_done}, 32'd1);
            check("dout", data_out, exp_dout);
            @(posedge clk);
            #1;
            check("done_clear", {31'd0, mem_done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        reset      = 1'b1;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_size   = 2'd0;
        mem_se     = 1'b0;
        address    = '0;
        data_in    = '0;
        exp_dout   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", data_out, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_done", {31'd0, mem_done}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;

        // Directed test plan.
        access(1'b1, 2'd2, 1'b0, 32'h004, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 32'h004, 32'h0);
        check("tp_word", data_out, 32'hDEADBEEF);
        access(1'b0, 2'd0, 1'b1, 32'h004, 32'h0);
        check("tp_lb_se", data_out, 32'hFFFFFFDE);
        access(1'b0, 2'd0, 1'b0, 32'h004, 32'h0);
        check("tp_lb_ze", data_out, 32'h000000DE);
        access(1'b0, 2'd1, 1'b1, 32'h006, 32'h0);
        check("tp_lh_se", data_out, 32'hFFFFBEEF);
        access(1'b1, 2'd0, 1'b0, 32'h005, 32'h0000007A);
        access(1'b0, 2'd2, 1'b0, 32'h004, 32'h0);
        check("tp_sb_word", data_out, 32'hDE7ABEEF);
        access(1'b0, 2'd2, 1'b0, 32'h006, 32'h0);
        check("tp_mis_keep", data_out, 32'hDE7ABEEF);
        access(1'b1, 2'd2, 1'b0, 32'h00A, 32'h55555555);
        access(1'b0, 2'd2, 1'b0, 32'h12345204, 32'h0);
        check("tp_wrap", data_out, 32'hDE7ABEEF);
        access(1'b1, 2'd2, 1'b0, 32'h1FC, 32'hA1B2C3D4);
        access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0);
        check("tp_last_half", data_out, 32'h0000C3D4);

        // Reset while a store is waiting: the store must be dropped.
        access(1'b1, 2'd2, 1'b0, 32'h010, 32'hCAFEF00D);
        @(negedge clk);
        mem_enable = 1'b1;
        mem_rw     = 1'b1;
        mem_size   = 2'd2;
        address    = 32'h010;
        data_in    = 32'h11223344;
        @(posedge clk);
        #2;
        reset      = 1'b1;
        mem_enable = 1'b0;
        exp_dout   = '0;
        #1;
        check("rst_wait_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_wait_dout", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, mem_done}, 32'd0);
        end
        access(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        check("rst_dropped", data_out, 32'hCAFEF00D);

        // Randomized traffic in a pre-filled window, with random upper address bits.
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom());
        end
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            a = (r & 32'hFFFF_FE00) | (32'h100 + 32'($urandom_range(0, 127)));
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
